// File: rtl/vga_timing_if.sv
// Timing outputs of the text-mode video sequencer, bundled for the pixel generator.
// `FRAME_COUNTER_EN adds the frame_count signal.
interface vga_timing_if #(
  parameter int SUB_PIXEL_WIDTH = 2,
  parameter int PIXEL_WIDTH     = 10,
  parameter int LINE_WIDTH      = 10
);
  logic                       enable;
  logic [SUB_PIXEL_WIDTH-1:0] pixel_state;
  logic [PIXEL_WIDTH-1:0]     pixel_counter;
  logic [LINE_WIDTH-1:0]      line_counter;
  logic                       hsync;
  logic                       vsync;
  logic                       visible;
  logic                       line_start;
  logic                       frame_start;
`ifdef FRAME_COUNTER_EN
  logic [7:0]                 frame_count;
`endif

  modport master (
`ifdef FRAME_COUNTER_EN
    output frame_count,
`endif
    input  enable,
    output pixel_state, pixel_counter, line_counter,
    output hsync, vsync, visible, line_start, frame_start
  );

  modport slave (
`ifdef FRAME_COUNTER_EN
    input  frame_count,
`endif
    output enable,
    input  pixel_state, pixel_counter, line_counter,
    input  hsync, vsync, visible, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_sequencer.sv
// Master timing sequencer: sub-pixel phase, pixel/line counters and sync decodes.
// `FRAME_COUNTER_EN adds an 8-bit wrapping frame counter on the interface.
module vga_timing_sequencer #(
  parameter int SUB_PIXEL_WIDTH = 2,
  parameter int PIXEL_WIDTH     = 10,
  parameter int LINE_WIDTH      = 10,
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master bus
);
  localparam int PIXELS = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int LINES  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [PIXEL_WIDTH-1:0] PIX_LAST = PIXEL_WIDTH'(PIXELS - 1);
  localparam logic [PIXEL_WIDTH-1:0] PIX_VIS  = PIXEL_WIDTH'(H_VISIBLE);
  localparam logic [PIXEL_WIDTH-1:0] HS_BEG   = PIXEL_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [PIXEL_WIDTH-1:0] HS_END   = PIXEL_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [LINE_WIDTH-1:0]  LINE_LAST = LINE_WIDTH'(LINES - 1);
  localparam logic [LINE_WIDTH-1:0]  LINE_VIS  = LINE_WIDTH'(V_VISIBLE);
  localparam logic [LINE_WIDTH-1:0]  VS_BEG    = LINE_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [LINE_WIDTH-1:0]  VS_END    = LINE_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [SUB_PIXEL_WIDTH-1:0] PH_DRAW = '1;

  logic [SUB_PIXEL_WIDTH-1:0] phase;
  logic [PIXEL_WIDTH-1:0]     pix;
  logic [LINE_WIDTH-1:0]      line;
  logic                       pix_wrap, line_wrap;

  // >= so a corrupted counter still returns to 0 on its next step
  assign pix_wrap  = (pix  >= PIX_LAST);
  assign line_wrap = (line >= LINE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      pix   <= '0;
      line  <= '0;
    end else if (bus.enable) begin
      phase <= phase + 1'b1;
      if (phase == PH_DRAW) begin
        pix <= pix_wrap ? '0 : pix + 1'b1;
        if (pix_wrap)
          line <= line_wrap ? '0 : line + 1'b1;
      end
    end
  end

  assign bus.pixel_state   = phase;
  assign bus.pixel_counter = pix;
  assign bus.line_counter  = line;
  assign bus.hsync         = !((pix  >= HS_BEG) && (pix  < HS_END));
  assign bus.vsync         = !((line >= VS_BEG) && (line < VS_END));
  assign bus.visible       = bus.enable && (pix < PIX_VIS) && (line < LINE_VIS);
  assign bus.line_start    = bus.enable && (pix == '0) && (phase == '0);
  assign bus.frame_start   = bus.line_start && (line == '0);

`ifdef FRAME_COUNTER_EN
  logic [7:0] frame_cnt;

  // frame_start already carries enable, so the count holds while frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                frame_cnt <= '0;
    else if (bus.frame_start) frame_cnt <= frame_cnt + 1'b1;
  end

  assign bus.frame_count = frame_cnt;
`endif
endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Bench for vga_timing_sequencer: full-size and abbreviated instances checked
// every cycle against a count-of-enabled-clocks model, plus literal anchors.
module tb_vga_timing_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  int   n;
  int   tests = 0, fails = 0;
  int   ls_full = 0, fs_small = 0, vd_small = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.SUB_PIXEL_WIDTH(2), .PIXEL_WIDTH(10), .LINE_WIDTH(10)) fb ();
  vga_timing_if #(.SUB_PIXEL_WIDTH(2), .PIXEL_WIDTH(10), .LINE_WIDTH(10)) sb ();
  assign fb.enable = enable;
  assign sb.enable = enable;

  vga_timing_sequencer dut_full (.clk(clk), .reset(reset), .bus(fb));

  vga_timing_sequencer #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_small (.clk(clk), .reset(reset), .bus(sb));

`ifdef FRAME_COUNTER_EN
  vga_timing_if #(.SUB_PIXEL_WIDTH(2), .PIXEL_WIDTH(10), .LINE_WIDTH(10)) tb_if ();
  assign tb_if.enable = enable;
  vga_timing_sequencer #(
    .H_VISIBLE(1), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_tiny (.clk(clk), .reset(reset), .bus(tb_if));
`endif

  // n = enabled clock edges since the last reset; every output follows from it
  always @(posedge clk or posedge reset) begin
    if (reset)       n <= 0;
    else if (enable) n <= n + 1;
  end

  typedef struct {
    int ph, pix, line;
    bit hs, vs, vis, ls, fs;
  } exp_t;

  function automatic exp_t model(input int cnt, input int hv, hf, hs, hb,
                                 input int vv, vf, vs, vb, input bit en);
    exp_t e;
    int pixels, lines;
    pixels = hv + hf + hs + hb;
    lines  = vv + vf + vs + vb;
    e.ph   = cnt % 4;
    e.pix  = (cnt / 4) % pixels;
    e.line = (cnt / (4 * pixels)) % lines;
    e.hs   = !(e.pix  >= hv + hf && e.pix  < hv + hf + hs);
    e.vs   = !(e.line >= vv + vf && e.line < vv + vf + vs);
    e.vis  = en && e.pix < hv && e.line < vv;
    e.ls   = en && e.pix == 0 && e.ph == 0;
    e.fs   = e.ls && e.line == 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input int ph, pix, line,
                           input bit hs, vs, vis, ls, fs);
    chk({tag, ".pixel_state"},   ph,  e.ph);
    chk({tag, ".pixel_counter"}, pix, e.pix);
    chk({tag, ".line_counter"},  line, e.line);
    chk({tag, ".hsync"},         hs,  e.hs);
    chk({tag, ".vsync"},         vs,  e.vs);
    chk({tag, ".visible"},       vis, e.vis);
    chk({tag, ".line_start"},    ls,  e.ls);
    chk({tag, ".frame_start"},   fs,  e.fs);
  endtask

  always @(negedge clk) begin
    exp_t ef, es;
    ef = model(n, 640, 16, 96, 48, 480, 10, 2, 33, enable);
    es = model(n, 16, 2, 4, 3, 6, 2, 2, 3, enable);
    check_dut("full", ef, fb.pixel_state, fb.pixel_counter, fb.line_counter,
              fb.hsync, fb.vsync, fb.visible, fb.line_start, fb.frame_start);
    check_dut("small", es, sb.pixel_state, sb.pixel_counter, sb.line_counter,
              sb.hsync, sb.vsync, sb.visible, sb.line_start, sb.frame_start);
`ifdef FRAME_COUNTER_EN
    chk("tiny.frame_count", tb_if.frame_count, ((n + 63) / 64) % 256);
`endif
    if (!reset) begin
      if (fb.line_start)                      ls_full  <= ls_full + 1;
      if (sb.frame_start)                     fs_small <= fs_small + 1;
      if (sb.visible && sb.pixel_state == 3)  vd_small <= vd_small + 1;
    end
  end

  // returns #1 after the edge on which n reaches target
  task automatic run_until(input int target);
    int guard = 0;
    while (n < target && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (n < target) begin
      fails++;
      $display("FAIL run_until: n=%0d, expected to reach %0d", n, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int ls0;
    int exp_ph [4] = '{1, 2, 3, 0};

    // reset state, with enable high so the pulse outputs follow enable
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pixel_counter", fb.pixel_counter, 0);
    chk("rst.hsync", fb.hsync, 1);
    chk("rst.vsync", fb.vsync, 1);
    chk("rst.visible", fb.visible, 1);
    #1 reset = 1'b0;
    #1 chk("first.frame_start", fb.frame_start, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("phase_seq", fb.pixel_state, exp_ph[i]);
    end
    ls0 = ls_full;

    // abbreviated frame: 25 px x 13 lines = 1300 clk, vsync on lines 8..9
    run_until(800);
    chk("small.line8", sb.line_counter, 8);
    chk("small.vsync_low", sb.vsync, 0);
    run_until(1000);
    chk("small.vsync_high", sb.vsync, 1);
    run_until(1300);
    chk("small.wrap_pix", sb.pixel_counter, 0);
    chk("small.wrap_line", sb.line_counter, 0);
    chk("small.wrap_fs", sb.frame_start, 1);
    run_until(1301);
    chk("small.frame_starts", fs_small, 2);
    chk("small.visible_draw", vd_small, 96);

    // full-size horizontal timing
    run_until(4 * 639 + 3);
    chk("full.vis_639", fb.visible, 1);
    run_until(4 * 640);
    chk("full.vis_640", fb.visible, 0);
    run_until(4 * 655 + 3);
    chk("full.hs_655", fb.hsync, 1);
    run_until(4 * 656);
    chk("full.hs_656", fb.hsync, 0);
    run_until(4 * 751 + 3);
    chk("full.hs_751", fb.hsync, 0);
    run_until(4 * 752);
    chk("full.hs_752", fb.hsync, 1);
    run_until(3200);
    chk("full.line1", fb.line_counter, 1);
    chk("full.line1_pix", fb.pixel_counter, 0);
    chk("full.line1_ls", fb.line_start, 1);
    run_until(3201);
    chk("full.ls_once", ls_full - ls0, 1);

    // freeze at pixel 100 phase 2, then resume
    do_reset();
    run_until(4 * 100 + 2);
    enable = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("hold.pix", fb.pixel_counter, 100);
    chk("hold.phase", fb.pixel_state, 2);
    chk("hold.visible", fb.visible, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("resume.phase", fb.pixel_state, 3);
    chk("resume.pix", fb.pixel_counter, 100);
    @(posedge clk); #1;
    chk("resume.pix_next", fb.pixel_counter, 101);

    // asynchronous clear mid-line
    run_until(4 * 300 + 1);
    chk("pre_rst.pix", fb.pixel_counter, 300);
    #2 reset = 1'b1;
    #1;
    chk("async.pix", fb.pixel_counter, 0);
    chk("async.phase", fb.pixel_state, 0);
    chk("async.line", fb.line_counter, 0);
    @(posedge clk); #2 reset = 1'b0;

`ifdef FRAME_COUNTER_EN
    // tiny frame is 4 px x 4 lines = 64 clk
    do_reset();
    run_until(255 * 64);
    chk("tiny.fc_255", tb_if.frame_count, 255);
    run_until(256 * 64);
    chk("tiny.fc_wrap", tb_if.frame_count, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
